// File: rtl/ann_neuron_sequencer_pkg.sv
// Shared types and default constants for the neuron sequencer slice:
// FSM state encoding, default geometry and Q8.8 saturation bounds.
package ann_pkg;

  localparam int unsigned DEPTH  = 28;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned ACC_W  = 40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LDFIN,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic longint sat_hi(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  localparam longint SAT_HI = sat_hi(DATA_W);
  localparam longint SAT_LO = sat_lo(DATA_W);

endpackage

// File: rtl/ann_neuron_sequencer_if.sv
// Scheduler handshake, weight-load stream and weight/pixel memory bus of
// one neuron sequencer. master = scheduler/memory side, slave = sequencer.
interface ann_neuron_sequencer_if #(
  parameter int unsigned ADDR_W = ann_pkg::ADDR_W,
  parameter int unsigned DATA_W = ann_pkg::DATA_W
);

  logic              START;
  logic [DATA_W-1:0] BIAS;
  logic              LOAD_REQ;
  logic              LD_VALID;
  logic [DATA_W-1:0] LD_DATA;
  logic [ADDR_W-1:0] W_ADDR;
  logic              W_EN;
  logic              W_WE;
  logic [DATA_W-1:0] W_DI;
  logic [DATA_W-1:0] W_DO;
  logic [ADDR_W-1:0] X_ADDR;
  logic [DATA_W-1:0] X_DATA;
  logic              BUSY;
  logic [DATA_W-1:0] RESULT;
  logic              VALID;
  logic              ACK;
  logic              LOAD_DONE;

  modport master (
    output START, BIAS, LOAD_REQ, LD_VALID, LD_DATA, W_DO, X_DATA, ACK,
    input  W_ADDR, W_EN, W_WE, W_DI, X_ADDR, BUSY, RESULT, VALID, LOAD_DONE
  );

  modport slave (
    input  START, BIAS, LOAD_REQ, LD_VALID, LD_DATA, W_DO, X_DATA, ACK,
    output W_ADDR, W_EN, W_WE, W_DI, X_ADDR, BUSY, RESULT, VALID, LOAD_DONE
  );

endinterface

// File: rtl/ann_neuron_sequencer_mac_sat.sv
// Registered signed MAC (bias preload, product pipeline register, accumulator)
// with shift/saturate output stage; ReLU when ANN_NEURON_SEQ_RELU_EN is defined.
module ann_mac_sat #(
  parameter int unsigned DATA_W = ann_pkg::DATA_W,
  parameter int unsigned FRAC_W = ann_pkg::FRAC_W,
  parameter int unsigned ACC_W  = ann_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_bias,
  input  logic                     mul_en,
  input  logic                     acc_en,
  input  logic                     res_load,
  input  logic signed [DATA_W-1:0] bias,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [DATA_W-1:0] x,
  output logic        [DATA_W-1:0] result
);
  import ann_pkg::*;

  localparam longint HI = sat_hi(DATA_W);
  localparam longint LO = sat_lo(DATA_W);

  logic signed [2*DATA_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d, acc_sh;
  logic        [DATA_W-1:0]   result_q, result_d, sat;

  always_comb begin
    prod_d   = prod_q;
    acc_d    = acc_q;
    result_d = result_q;
    acc_sh   = acc_q >>> FRAC_W;

    if (longint'(acc_sh) > HI) begin
      sat = DATA_W'(HI);
    end else if (longint'(acc_sh) < LO) begin
      sat = DATA_W'(LO);
    end else begin
      sat = acc_sh[DATA_W-1:0];
    end
`ifdef ANN_NEURON_SEQ_RELU_EN
    if (sat[DATA_W-1]) begin
      sat = '0;
    end
`endif

    // The product register lags the BRAM by one cycle, so the accumulator
    // always adds the product captured on the previous edge.
    if (mul_en) begin
      prod_d = w * x;
    end
    if (load_bias) begin
      acc_d = ACC_W'(bias) <<< FRAC_W;
    end else if (acc_en) begin
      acc_d = acc_q + ACC_W'(prod_q);
    end
    if (res_load) begin
      result_d = sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/ann_neuron_sequencer.sv
// Neuron dot-product sequencer: owns the weight BRAM port (reload and read),
// drives the pixel address and hands results to the scheduler. Optional
// ReLU output via ANN_NEURON_SEQ_RELU_EN (implemented in ann_mac_sat).
module ann_neuron_sequencer #(
  parameter int unsigned DEPTH  = ann_pkg::DEPTH,
  parameter int unsigned ADDR_W = ann_pkg::ADDR_W,
  parameter int unsigned DATA_W = ann_pkg::DATA_W,
  parameter int unsigned FRAC_W = ann_pkg::FRAC_W,
  parameter int unsigned ACC_W  = ann_pkg::ACC_W
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  ann_neuron_sequencer_if.slave   bus
);
  import ann_pkg::*;

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [ADDR_W-1:0]   x_addr_q, x_addr_d;
  logic                w_en_q, w_en_d;
  logic                w_we_q, w_we_d;
  logic [DATA_W-1:0]   w_di_q, w_di_d;
  logic                valid_q, valid_d;
  logic                load_done_q, load_done_d;
  logic                busy_q, busy_d;

  logic                load_bias, mul_en, acc_en, res_load;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_addr_d    = w_addr_q;
    x_addr_d    = x_addr_q;
    w_en_d      = 1'b0;
    w_we_d      = 1'b0;
    w_di_d      = w_di_q;
    valid_d     = valid_q;
    load_done_d = 1'b0;
    load_bias   = 1'b0;
    mul_en      = 1'b0;
    acc_en      = 1'b0;
    res_load    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.LOAD_REQ) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else if (bus.START) begin
          state_d   = ST_READ;
          cnt_d     = '0;
          w_addr_d  = '0;
          x_addr_d  = '0;
          w_en_d    = 1'b1;
          load_bias = 1'b1;
        end
      end

      ST_LOAD: begin
        if (bus.LD_VALID) begin
          w_en_d   = 1'b1;
          w_we_d   = 1'b1;
          w_addr_d = cnt_q;
          w_di_d   = bus.LD_DATA;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_LDFIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_LDFIN: begin
        load_done_d = 1'b1;
        state_d     = ST_IDLE;
      end

      // Edge k+1 captures the product for address k; edge k+2 accumulates it.
      ST_READ: begin
        mul_en = 1'b1;
        acc_en = (cnt_q != '0);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          w_addr_d = cnt_q + 1'b1;
          x_addr_d = cnt_q + 1'b1;
          w_en_d   = 1'b1;
        end
      end

      ST_DRAIN: begin
        acc_en  = 1'b1;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (!valid_q) begin
          res_load = 1'b1;
          valid_d  = 1'b1;
        end else if (bus.ACK) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      w_addr_q    <= '0;
      x_addr_q    <= '0;
      w_en_q      <= 1'b0;
      w_we_q      <= 1'b0;
      w_di_q      <= '0;
      valid_q     <= 1'b0;
      load_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      w_addr_q    <= w_addr_d;
      x_addr_q    <= x_addr_d;
      w_en_q      <= w_en_d;
      w_we_q      <= w_we_d;
      w_di_q      <= w_di_d;
      valid_q     <= valid_d;
      load_done_q <= load_done_d;
      busy_q      <= busy_d;
    end
  end

  ann_mac_sat #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk       (CLK),
    .rst_n     (RST_N),
    .load_bias (load_bias),
    .mul_en    (mul_en),
    .acc_en    (acc_en),
    .res_load  (res_load),
    .bias      (bus.BIAS),
    .w         (bus.W_DO),
    .x         (bus.X_DATA),
    .result    (bus.RESULT)
  );

  assign bus.W_ADDR    = w_addr_q;
  assign bus.X_ADDR    = x_addr_q;
  assign bus.W_EN      = w_en_q;
  assign bus.W_WE      = w_we_q;
  assign bus.W_DI      = w_di_q;
  assign bus.VALID     = valid_q;
  assign bus.LOAD_DONE = load_done_q;
  assign bus.BUSY      = busy_q;

endmodule
